nrisc_multiciclo: RTL and testbench

- Parametrised multi-cycle successor of the single-cycle nRisc core.
- Executes the same 8-bit instruction format (3-bit opcode, 2-bit register A field, 3-bit register B / immediate field) through an explicit FSM.
- Fetches instructions and accesses data through request/acknowledge handshakes, so wait-state memories are supported.
- Data and PC widths are generic; adds a HALT instruction and synchronous reset, which the previous core lacks.

---
 rtl/nrisc_multiciclo_if.sv | 30 +++
 rtl/nrisc_multiciclo.sv | 160 ++++++++++++++++
 tb/tb_nrisc_multiciclo.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nrisc_multiciclo_if.sv
// Instruction/data bus bundle of the multi-cycle nRisc core.
// The core takes the master side; memories take the slave side.
interface nrisc_multiciclo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PC_WIDTH   = 8
);
    logic [PC_WIDTH-1:0]   SaidaPC;
    logic                  InstrReq;
    logic                  InstrValid;
    logic [7:0]            Instrucao;
    logic                  DataReq;
    logic                  DataWe;
    logic [DATA_WIDTH-1:0] EndMemDados;
    logic [DATA_WIDTH-1:0] DadoEscritoMem;
    logic                  DataAck;
    logic [DATA_WIDTH-1:0] DadoLidoMem;
    logic                  Halted;

    modport master (
        output SaidaPC, InstrReq, DataReq, DataWe,
        output EndMemDados, DadoEscritoMem, Halted,
        input  InstrValid, Instrucao, DataAck, DadoLidoMem
    );

    modport slave (
        input  SaidaPC, InstrReq, DataReq, DataWe,
        input  EndMemDados, DadoEscritoMem, Halted,
        output InstrValid, Instrucao, DataAck, DadoLidoMem
    );
endinterface

// File: rtl/nrisc_multiciclo.sv
// Multi-cycle nRisc core: FETCH/DECODE/EXEC/MEM/WB/HALT FSM with
// request/acknowledge instruction and data buses.
module nrisc_multiciclo #(
    parameter int                  DATA_WIDTH = 8,
    parameter int                  PC_WIDTH   = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic               Clock,
    input  logic               ResetN,
    nrisc_multiciclo_if.master bus
);

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_ADDI  = 3'd2;
    localparam logic [2:0] OP_LOAD  = 3'd3;
    localparam logic [2:0] OP_STORE = 3'd4;
    localparam logic [2:0] OP_BEQZ  = 3'd5;
    localparam logic [2:0] OP_JUMP  = 3'd6;
    localparam logic [2:0] OP_HALT  = 3'd7;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t                r_state;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [7:0]            r_ir;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_res;
    logic [DATA_WIDTH-1:0] r_rf [8];
    logic                  r_instr_req;
    logic                  r_data_req;
    logic                  r_data_we;
    logic                  r_halted;
    logic [DATA_WIDTH-1:0] r_end_mem;
    logic [DATA_WIDTH-1:0] r_dado_esc;

    logic [2:0]            w_op;
    logic [2:0]            w_ra;
    logic [2:0]            w_rb;
    logic [DATA_WIDTH-1:0] w_imm;
    logic [PC_WIDTH-1:0]   w_tgt;
    logic [PC_WIDTH-1:0]   w_pc_inc;

    assign w_op     = r_ir[7:5];
    assign w_ra     = {1'b0, r_ir[4:3]};
    assign w_rb     = r_ir[2:0];
    assign w_imm    = {{(DATA_WIDTH-3){r_ir[2]}}, r_ir[2:0]};
    // Branch targets are truncated or zero-extended to the PC width
    assign w_tgt    = PC_WIDTH'(r_b);
    assign w_pc_inc = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            for (int i = 0; i < 8; i++) r_rf[i] <= '0;
            r_instr_req <= 1'b0;
            r_data_req  <= 1'b0;
            r_data_we   <= 1'b0;
            r_halted    <= 1'b0;
            r_end_mem   <= '0;
            r_dado_esc  <= '0;
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    // The first cycle out of reset only raises the request
                    if (r_instr_req && bus.InstrValid) begin
                        r_ir        <= bus.Instrucao;
                        r_instr_req <= 1'b0;
                        r_state     <= S_DECODE;
                    end else begin
                        r_instr_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    r_a     <= r_rf[w_ra];
                    r_b     <= r_rf[w_rb];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    unique case (w_op)
                        OP_ADD: begin
                            r_res   <= r_a + r_b;
                            r_state <= S_WB;
                        end
                        OP_SUB: begin
                            r_res   <= r_a - r_b;
                            r_state <= S_WB;
                        end
                        OP_ADDI: begin
                            r_res   <= r_a + w_imm;
                            r_state <= S_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            r_data_req <= 1'b1;
                            r_data_we  <= (w_op == OP_STORE);
                            r_end_mem  <= r_b;
                            r_dado_esc <= r_a;
                            r_state    <= S_MEM;
                        end
                        OP_BEQZ: begin
                            r_pc        <= (r_a == '0) ? w_tgt : w_pc_inc;
                            r_instr_req <= 1'b1;
                            r_state     <= S_FETCH;
                        end
                        OP_JUMP: begin
                            r_pc        <= w_tgt;
                            r_instr_req <= 1'b1;
                            r_state     <= S_FETCH;
                        end
                        OP_HALT: begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end
                    endcase
                end
                S_MEM: begin
                    if (bus.DataAck) begin
                        r_data_req <= 1'b0;
                        r_data_we  <= 1'b0;
                        if (w_op == OP_STORE) begin
                            r_pc        <= w_pc_inc;
                            r_instr_req <= 1'b1;
                            r_state     <= S_FETCH;
                        end else begin
                            r_res   <= bus.DadoLidoMem;
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    r_rf[w_ra]  <= r_res;
                    r_pc        <= w_pc_inc;
                    r_instr_req <= 1'b1;
                    r_state     <= S_FETCH;
                end
                S_HALT: begin
                    r_halted <= 1'b1;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign bus.SaidaPC        = r_pc;
    assign bus.InstrReq       = r_instr_req;
    assign bus.DataReq        = r_data_req;
    assign bus.DataWe         = r_data_we;
    assign bus.EndMemDados    = r_end_mem;
    assign bus.DadoEscritoMem = r_dado_esc;
    assign bus.Halted         = r_halted;

endmodule

// File: tb/tb_nrisc_multiciclo.sv
// Bench for nrisc_multiciclo: 8/8 core with wait-state memory model
// plus a 16/10 core with zero-wait memory.
module tb_nrisc_multiciclo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    nrisc_multiciclo_if #(.DATA_WIDTH(8),  .PC_WIDTH(8))  ifa ();
    nrisc_multiciclo_if #(.DATA_WIDTH(16), .PC_WIDTH(10)) ifb ();

    nrisc_multiciclo #(.DATA_WIDTH(8), .PC_WIDTH(8), .RESET_PC(8'h00)) dut_a (
        .Clock  (clk),
        .ResetN (rst_a),
        .bus    (ifa.master)
    );

    nrisc_multiciclo #(.DATA_WIDTH(16), .PC_WIDTH(10), .RESET_PC(10'h000)) dut_b (
        .Clock  (clk),
        .ResetN (rst_b),
        .bus    (ifb.master)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] qf_a [$];
    logic [31:0] qs_a [$];
    logic [31:0] qf_b [$];
    logic [31:0] qs_b [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ins(input int op, input int ra, input int rb);
        return {op[2:0], ra[1:0], rb[2:0]};
    endfunction

    function automatic logic [31:0] sd(input int a, input int d);
        return {a[15:0], d[15:0]};
    endfunction

    // Memory model for the 8-bit core
    logic [7:0] imem_a  [256];
    logic [7:0] dinit_a [256];
    logic [7:0] dmem_a  [256];
    int  dwait  = 0;
    int  dcnt   = 0;
    bit  istall = 1'b0;
    bit  dforce = 1'b0;
    int  run_a  = 0;

    assign ifa.InstrValid  = ifa.InstrReq && !istall;
    assign ifa.Instrucao   = imem_a[ifa.SaidaPC];
    assign ifa.DataAck     = (ifa.DataReq && dcnt >= dwait) || dforce;
    assign ifa.DadoLidoMem = dmem_a[ifa.EndMemDados];

    always @(posedge clk) begin
        dcnt <= (ifa.DataReq && !ifa.DataAck) ? dcnt + 1 : 0;
        if (!rst_a) dmem_a <= dinit_a;
        else if (ifa.DataReq && ifa.DataAck && ifa.DataWe)
            dmem_a[ifa.EndMemDados] <= ifa.DadoEscritoMem;
        if (!rst_a) run_a <= 0;
        else if (!ifa.Halted) run_a <= run_a + 1;
    end

    always @(negedge clk) begin
        if (rst_a && ifa.InstrReq && ifa.InstrValid)
            chk("fetch_a", 32'(ifa.SaidaPC), qf_a.size() != 0 ? qf_a.pop_front() : 32'hFFFFFFFF);
        if (rst_a && ifa.DataReq && ifa.DataAck && ifa.DataWe)
            chk("store_a", {16'(ifa.EndMemDados), 16'(ifa.DadoEscritoMem)},
                qs_a.size() != 0 ? qs_a.pop_front() : 32'hFFFFFFFF);
    end

    // Zero-wait memory model for the 16/10 core
    logic [7:0]  imem_b [1024];
    logic [15:0] dmem_b [16];

    assign ifb.InstrValid  = ifb.InstrReq;
    assign ifb.Instrucao   = imem_b[ifb.SaidaPC];
    assign ifb.DataAck     = ifb.DataReq;
    assign ifb.DadoLidoMem = dmem_b[ifb.EndMemDados[3:0]];

    always @(negedge clk) begin
        if (rst_b && ifb.InstrReq && ifb.InstrValid)
            chk("fetch_b", 32'(ifb.SaidaPC), qf_b.size() != 0 ? qf_b.pop_front() : 32'hFFFFFFFF);
        if (rst_b && ifb.DataReq && ifb.DataAck && ifb.DataWe)
            chk("store_b", {16'(ifb.EndMemDados), ifb.DadoEscritoMem},
                qs_b.size() != 0 ? qs_b.pop_front() : 32'hFFFFFFFF);
    end

    task automatic clear_a();
        for (int i = 0; i < 256; i++) begin
            imem_a[i]  = 8'hE0;
            dinit_a[i] = 8'h00;
        end
        qf_a.delete();
        qs_a.delete();
    endtask

    task automatic rel_a();
        @(negedge clk);
        rst_a = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc",    32'(ifa.SaidaPC), 0);
        chk("rst_ireq",  32'(ifa.InstrReq), 0);
        chk("rst_dreq",  32'(ifa.DataReq), 0);
        chk("rst_we",    32'(ifa.DataWe), 0);
        chk("rst_halt",  32'(ifa.Halted), 0);
        chk("rst_addr",  32'(ifa.EndMemDados), 0);
        chk("rst_wdata", 32'(ifa.DadoEscritoMem), 0);
        rst_a = 1'b1;
        @(negedge clk);
        chk("rel_ireq", 32'(ifa.InstrReq), 1);
        chk("rel_pc",   32'(ifa.SaidaPC), 0);
    endtask

    task automatic wait_halt_a(input int max);
        int n = 0;
        while (!ifa.Halted && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("halt_a", 32'(ifa.Halted), 1);
    endtask

    task automatic done_a();
        @(negedge clk);
        chk("halt_ireq", 32'(ifa.InstrReq), 0);
        chk("halt_dreq", 32'(ifa.DataReq), 0);
        chk("fq_a_empty", 32'(qf_a.size()), 0);
        chk("sq_a_empty", 32'(qs_a.size()), 0);
    endtask

    task automatic wait_dreq_a(input int max);
        int n = 0;
        while (!ifa.DataReq && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("dreq_a_wait", 32'(ifa.DataReq), 1);
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int i = 0; i < 1024; i++) imem_b[i] = 8'hE0;
        for (int i = 0; i < 16; i++) dmem_b[i] = 16'h0000;

        // ALU program cycle count
        clear_a();
        imem_a[0] = ins(2, 1, 3);
        imem_a[1] = ins(2, 1, 7);
        imem_a[2] = ins(1, 1, 1);
        imem_a[3] = ins(7, 0, 0);
        for (int i = 0; i < 4; i++) qf_a.push_back(i);
        rel_a();
        wait_halt_a(200);
        chk("alu_cycles", run_a, 1 + 15);
        done_a();

        // ALU values and 8-bit wrap, observed through stores
        clear_a();
        imem_a[0] = ins(2, 1, 3);
        imem_a[1] = ins(4, 1, 0);
        imem_a[2] = ins(2, 1, 7);
        imem_a[3] = ins(4, 1, 0);
        imem_a[4] = ins(1, 1, 1);
        imem_a[5] = ins(4, 1, 0);
        imem_a[6] = ins(2, 2, 7);
        imem_a[7] = ins(4, 2, 0);
        for (int i = 0; i < 9; i++) qf_a.push_back(i);
        qs_a.push_back(sd(0, 3));
        qs_a.push_back(sd(0, 2));
        qs_a.push_back(sd(0, 0));
        qs_a.push_back(sd(0, 8'hFF));
        rel_a();
        wait_halt_a(200);
        done_a();

        // Load/store with and without data wait states
        for (int k = 0; k < 2; k++) begin
            int w;
            w = (k == 0) ? 3 : 0;
            clear_a();
            dwait = w;
            imem_a[0] = ins(2, 1, 3);
            imem_a[1] = ins(2, 1, 2);
            imem_a[2] = ins(2, 2, 3);
            imem_a[3] = ins(2, 2, 3);
            imem_a[4] = ins(2, 2, 1);
            imem_a[5] = ins(4, 1, 2);
            imem_a[6] = ins(3, 3, 2);
            imem_a[7] = ins(4, 3, 0);
            for (int i = 0; i < 9; i++) qf_a.push_back(i);
            qs_a.push_back(sd(7, 5));
            qs_a.push_back(sd(0, 5));
            rel_a();
            if (w != 0) begin
                wait_dreq_a(100);
                for (int c = 0; c < 4; c++) begin
                    chk("ws_addr", 32'(ifa.EndMemDados), 7);
                    chk("ws_we",   32'(ifa.DataWe), 1);
                    chk("ws_data", 32'(ifa.DadoEscritoMem), 5);
                    chk("ws_req",  32'(ifa.DataReq), 1);
                    @(negedge clk);
                end
            end
            wait_halt_a(300);
            chk("ls_cycles", run_a, 1 + 36 + 3 * w);
            done_a();
        end
        dwait = 0;

        // Fetch stall
        clear_a();
        imem_a[0] = ins(2, 1, 1);
        imem_a[1] = ins(4, 1, 0);
        qf_a.push_back(0);
        qf_a.push_back(1);
        qf_a.push_back(2);
        qs_a.push_back(sd(0, 1));
        istall = 1'b1;
        rel_a();
        for (int c = 0; c < 5; c++) begin
            chk("stall_ireq", 32'(ifa.InstrReq), 1);
            chk("stall_pc",   32'(ifa.SaidaPC), 0);
            @(negedge clk);
        end
        istall = 1'b0;
        wait_halt_a(200);
        done_a();

        // Reset while waiting in MEM, then a stale ack
        clear_a();
        imem_a[0]  = ins(3, 1, 0);
        imem_a[1]  = ins(4, 1, 0);
        dinit_a[0] = 8'h5A;
        dwait = 10;
        qf_a.push_back(0);
        rel_a();
        wait_dreq_a(50);
        rst_a = 1'b0;
        @(negedge clk);
        chk("mid_dreq", 32'(ifa.DataReq), 0);
        chk("mid_pc",   32'(ifa.SaidaPC), 0);
        chk("mid_ireq", 32'(ifa.InstrReq), 0);
        istall = 1'b1;
        dforce = 1'b1;
        rst_a  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stale_dreq", 32'(ifa.DataReq), 0);
            chk("stale_ireq", 32'(ifa.InstrReq), 1);
            chk("stale_pc",   32'(ifa.SaidaPC), 0);
        end
        dforce = 1'b0;
        dwait  = 0;
        for (int i = 0; i < 3; i++) qf_a.push_back(i);
        qs_a.push_back(sd(0, 8'h5A));
        istall = 1'b0;
        wait_halt_a(200);
        done_a();

        // Every register reads zero after reset
        clear_a();
        for (int r = 0; r < 4; r++) imem_a[r] = ins(4, r, 0);
        imem_a[4] = ins(4, 0, 5);
        imem_a[5] = ins(4, 0, 7);
        for (int i = 0; i < 7; i++) qf_a.push_back(i);
        for (int i = 0; i < 6; i++) qs_a.push_back(sd(0, 0));
        rel_a();
        wait_halt_a(200);
        done_a();

        // Branches taken/not taken and jumps to/from 0xFF
        clear_a();
        dinit_a[0]   = 8'h20;
        dinit_a[1]   = 8'hFF;
        dinit_a[2]   = 8'hFE;
        imem_a[8'h00] = ins(3, 1, 0);
        imem_a[8'h01] = ins(5, 0, 1);
        imem_a[8'h20] = ins(2, 0, 1);
        imem_a[8'h21] = ins(5, 0, 1);
        imem_a[8'h22] = ins(3, 3, 0);
        imem_a[8'h23] = ins(6, 0, 3);
        imem_a[8'hFF] = ins(6, 0, 1);
        qf_a.push_back(8'h00);
        qf_a.push_back(8'h01);
        qf_a.push_back(8'h20);
        qf_a.push_back(8'h21);
        qf_a.push_back(8'h22);
        qf_a.push_back(8'h23);
        qf_a.push_back(8'hFF);
        qf_a.push_back(8'h20);
        qf_a.push_back(8'h21);
        qf_a.push_back(8'h22);
        qf_a.push_back(8'h23);
        qf_a.push_back(8'hFE);
        rel_a();
        wait_halt_a(300);
        done_a();

        // Sequential PC wrap from 0xFF to 0x00
        clear_a();
        dinit_a[0]    = 8'hFF;
        dinit_a[1]    = 8'h10;
        imem_a[8'h00] = ins(3, 1, 0);
        imem_a[8'h01] = ins(6, 0, 1);
        imem_a[8'hFF] = ins(2, 0, 1);
        qf_a.push_back(8'h00);
        qf_a.push_back(8'h01);
        qf_a.push_back(8'hFF);
        qf_a.push_back(8'h00);
        qf_a.push_back(8'h01);
        qf_a.push_back(8'h10);
        rel_a();
        wait_halt_a(300);
        done_a();

        // 16-bit data, 10-bit PC core
        dmem_b[0] = 16'h0405;
        dmem_b[1] = 16'hFFFF;
        imem_b[0] = ins(3, 3, 0);
        imem_b[1] = ins(2, 2, 1);
        imem_b[2] = ins(3, 1, 2);
        imem_b[3] = ins(6, 0, 3);
        imem_b[5] = ins(0, 1, 2);
        imem_b[6] = ins(4, 1, 0);
        imem_b[7] = ins(4, 3, 2);
        qf_b.push_back(0);
        qf_b.push_back(1);
        qf_b.push_back(2);
        qf_b.push_back(3);
        qf_b.push_back(5);
        qf_b.push_back(6);
        qf_b.push_back(7);
        qf_b.push_back(8);
        qs_b.push_back(sd(0, 0));
        qs_b.push_back(sd(1, 16'h0405));
        @(negedge clk);
        rst_b = 1'b1;
        begin
            int n = 0;
            while (!ifb.Halted && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        chk("halt_b",     32'(ifb.Halted), 1);
        chk("halt_b_pc",  32'(ifb.SaidaPC), 8);
        chk("fq_b_empty", 32'(qf_b.size()), 0);
        chk("sq_b_empty", 32'(qs_b.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
